// File: rtl/scroll_pkg.sv
// ---------------------------------------------------------------------------
// scroll_pkg
// Shared types and constants for the scrolling message controller.
//   state_e     : controller states (IDLE, LOAD, SCROLL, HOLD), encoded as
//                 seen on state_o
//   char_t      : one ASCII character
//   ASCII_SPACE : blank character shown on every digit while no message is
//                 being scrolled
// ---------------------------------------------------------------------------
package scroll_pkg;

    localparam int CHAR_W = 8;

    typedef logic [CHAR_W-1:0] char_t;

    localparam char_t ASCII_SPACE = 8'h20;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SCROLL = 2'd2,
        HOLD   = 2'd3
    } state_e;

endpackage

// File: rtl/scroll_msg_ctrl_if.sv
// ---------------------------------------------------------------------------
// scroll_msg_ctrl_if
// Character write stream from a message requester into the controller.
//   wr_valid : requester presents a character
//   wr_ready : controller accepts the character this cycle
//   wr_char  : ASCII character
//   wr_last  : final character of the message
// Handshake: a beat transfers on every rising clock edge where
// wr_valid && wr_ready. The controller holds wr_ready high in every state,
// so a requester never has to stall; wr_char/wr_last are only meaningful
// while wr_valid is high.
// Modports: master = requester side, slave = controller side.
// ---------------------------------------------------------------------------
interface scroll_msg_ctrl_if #(
    parameter int CHAR_WIDTH = 8
);
    logic                  wr_valid;
    logic                  wr_ready;
    logic [CHAR_WIDTH-1:0] wr_char;
    logic                  wr_last;

    modport master (
        output wr_valid,
        output wr_char,
        output wr_last,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_char,
        input  wr_last,
        output wr_ready
    );
endinterface

// File: rtl/wrap_index.sv
// ---------------------------------------------------------------------------
// wrap_index
// Combinational (pos + K) mod len for one display digit, without a divider.
//   pos : current scroll position, always < len while a message is shown
//   len : message length (>= 1 whenever the result is used)
//   idx : buffer index of the character shown on this digit
// Parameters: W = index width, K = digit offset from the leftmost digit,
// STAGES = number of conditional-subtract stages.
// With pos < len and K < NUM_DISPLAYS, the sum exceeds len by at most
// NUM_DISPLAYS-1 multiples (worst case len = 1), so NUM_DISPLAYS+1 stages
// always reduce it fully. len = 0 only occurs when the output is ignored;
// subtracting zero is then a harmless no-op.
// ---------------------------------------------------------------------------
module wrap_index #(
    parameter int W      = 5,
    parameter int K      = 0,
    parameter int STAGES = 7
) (
    input  logic [W-1:0] pos,
    input  logic [W-1:0] len,
    output logic [W-1:0] idx
);
    // Wide enough to hold (2^W - 1) + K without overflow.
    localparam int SW = W + $clog2(K + 2);

    logic [SW-1:0] len_ext;
    logic [SW-1:0] acc;

    always_comb begin
        len_ext = SW'(len);
        acc     = SW'(pos) + SW'(K);
        for (int s = 0; s < STAGES; s++) begin
            if (acc >= len_ext) begin
                acc = acc - len_ext;
            end
        end
        idx = W'(acc);
    end
endmodule

// File: rtl/scroll_msg_ctrl.sv
// ---------------------------------------------------------------------------
// scroll_msg_ctrl
// Loads a message over a valid/ready character stream into a buffer and
// scrolls it across a NUM_DISPLAYS-digit seven-segment window, one step per
// unpaused speed tick, dwelling HOLD_TICKS ticks at position 0 after each
// full loop.
// Ports:
//   clk_50mhz, reset_n : clock, asynchronous active-low reset
//   tick               : one-cycle scroll-step strobe
//   dir_switch         : 1 = pos increments, 0 = pos decrements
//   pause_switch       : 1 = ticks ignored
//   wr                 : character write stream (slave side)
//   display_chars      : registered window, [NUM_DISPLAYS-1] = leftmost
//   msg_len            : stored message length
//   frame_done         : one-cycle pulse when pos wraps into 0
//   state_o            : current state (IDLE=0, LOAD=1, SCROLL=2, HOLD=3)
// ---------------------------------------------------------------------------
module scroll_msg_ctrl
    import scroll_pkg::*;
#(
    parameter int MSG_MAX      = 16,
    parameter int CHAR_WIDTH   = 8,
    parameter int NUM_DISPLAYS = 6,
    parameter int HOLD_TICKS   = 3
) (
    input  logic                         clk_50mhz,
    input  logic                         reset_n,
    input  logic                         tick,
    input  logic                         dir_switch,
    input  logic                         pause_switch,
    scroll_msg_ctrl_if.slave             wr,
    output logic [CHAR_WIDTH-1:0]        display_chars [NUM_DISPLAYS-1:0],
    output logic [$clog2(MSG_MAX+1)-1:0] msg_len,
    output logic                         frame_done,
    output logic [1:0]                   state_o
);
    localparam int LEN_W = $clog2(MSG_MAX + 1);
    localparam int AW    = (MSG_MAX > 1) ? $clog2(MSG_MAX) : 1;
    localparam int HC_W  = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;

    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MSG_MAX);
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
    localparam logic [HC_W-1:0]  HOLD_END = HC_W'(HOLD_TICKS);
    localparam logic [HC_W-1:0]  HC_ONE   = HC_W'(1);

    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_LOAD   = LOAD;
    localparam logic [1:0] S_SCROLL = SCROLL;
    localparam logic [1:0] S_HOLD   = HOLD;

    localparam logic [CHAR_WIDTH-1:0] SPACE = CHAR_WIDTH'(ASCII_SPACE);

    logic [1:0]            state_q, state_d;
    logic [LEN_W-1:0]      pos_q, pos_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [HC_W-1:0]       hold_q, hold_d;
    logic                  frame_done_q, frame_done_d;
    logic [CHAR_WIDTH-1:0] disp_q [NUM_DISPLAYS-1:0];
    logic [CHAR_WIDTH-1:0] disp_d [NUM_DISPLAYS-1:0];
    logic [CHAR_WIDTH-1:0] buffer_q [MSG_MAX];

    logic                  beat;
    logic                  step_en;
    logic [LEN_W-1:0]      pos_step;
    logic                  buf_we;
    logic [AW-1:0]         buf_waddr;
    logic [CHAR_WIDTH-1:0] buf_wdata;
    logic [LEN_W-1:0]      win_idx [NUM_DISPLAYS];
    logic                  show;

    // No backpressure: every presented character is taken.
    assign wr.wr_ready = 1'b1;
    assign beat        = wr.wr_valid && wr.wr_ready;
    assign step_en     = tick && !pause_switch;

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d      = state_q;
        pos_d        = pos_q;
        len_d        = len_q;
        hold_d       = hold_q;
        frame_done_d = 1'b0;
        buf_we       = 1'b0;
        buf_waddr    = '0;
        buf_wdata    = wr.wr_char;

        // Candidate position for one scroll step, wrapping at either end.
        if (dir_switch) begin
            pos_step = (pos_q == len_q - LEN_ONE) ? '0 : pos_q + LEN_ONE;
        end else begin
            pos_step = (pos_q == '0) ? len_q - LEN_ONE : pos_q - LEN_ONE;
        end

        case (state_q)
            S_LOAD: begin
                if (beat) begin
                    // Characters past the buffer depth are accepted but dropped.
                    if (len_q < LEN_MAX) begin
                        buf_we    = 1'b1;
                        buf_waddr = AW'(len_q);
                        len_d     = len_q + LEN_ONE;
                    end
                    if (wr.wr_last) begin
                        state_d = S_SCROLL;
                        pos_d   = '0;
                    end
                end
            end
            default: begin
                // IDLE, SCROLL, HOLD: a beat always starts a new message and
                // takes priority over a tick in the same cycle.
                if (beat) begin
                    buf_we    = 1'b1;
                    buf_waddr = '0;
                    len_d     = LEN_ONE;
                    pos_d     = '0;
                    hold_d    = '0;
                    state_d   = wr.wr_last ? S_SCROLL : S_LOAD;
                end else if (state_q == S_SCROLL && step_en) begin
                    pos_d = pos_step;
                    // Landing on 0 from either direction completes a loop.
                    if (pos_step == '0) begin
                        frame_done_d = 1'b1;
                        if (HOLD_TICKS > 0) begin
                            state_d = S_HOLD;
                            hold_d  = '0;
                        end
                    end
                end else if (state_q == S_HOLD && step_en) begin
                    hold_d = hold_q + HC_ONE;
                    if (hold_d == HOLD_END) begin
                        state_d = S_SCROLL;
                    end
                end
            end
        endcase
    end

    // ---------------- display window ----------------
    for (genvar k = 0; k < NUM_DISPLAYS; k++) begin : g_win
        wrap_index #(
            .W      (LEN_W),
            .K      (k),
            .STAGES (NUM_DISPLAYS + 1)
        ) u_wrap (
            .pos (pos_q),
            .len (len_q),
            .idx (win_idx[k])
        );
    end

    assign show = (state_q == S_SCROLL) || (state_q == S_HOLD);

    // Built from the registered pos/state, so the window lags pos by one edge.
    always_comb begin
        for (int k = 0; k < NUM_DISPLAYS; k++) begin
            disp_d[NUM_DISPLAYS-1-k] = show ? buffer_q[AW'(win_idx[k])] : SPACE;
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk_50mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            pos_q        <= '0;
            len_q        <= '0;
            hold_q       <= '0;
            frame_done_q <= 1'b0;
            for (int k = 0; k < NUM_DISPLAYS; k++) begin
                disp_q[k] <= SPACE;
            end
        end else begin
            state_q      <= state_d;
            pos_q        <= pos_d;
            len_q        <= len_d;
            hold_q       <= hold_d;
            frame_done_q <= frame_done_d;
            disp_q       <= disp_d;
        end
    end

    // Message storage has no reset; unused entries are never displayed.
    always_ff @(posedge clk_50mhz) begin
        if (buf_we) begin
            buffer_q[buf_waddr] <= buf_wdata;
        end
    end

    assign display_chars = disp_q;
    assign msg_len       = len_q;
    assign frame_done    = frame_done_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_scroll_msg_ctrl.sv
module tb_scroll_msg_ctrl;

    localparam int CW = 8;
    localparam int ND = 6;
    localparam int MM = 16;
    localparam int HT = 3;

    localparam logic [47:0] SPACES = 48'h202020202020;
    localparam logic [47:0] W_HELLOH = 48'h48454C4C4F48;
    localparam logic [47:0] W_ELLOHE = 48'h454C4C4F4845;
    localparam logic [47:0] W_OHELLO = 48'h4F48454C4C4F;

    localparam int K_STATE = 0;
    localparam int K_LEN   = 1;
    localparam int K_DISP  = 2;
    localparam int K_FD    = 3;
    localparam int K_RDY   = 4;

    typedef struct {
        int          due;
        int          kind;
        logic [47:0] exp;
        string       name;
    } exp_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n;
    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic                         tick;
    logic                         dir_switch;
    logic                         pause_switch;
    logic [CW-1:0]                display_chars [ND-1:0];
    logic [$clog2(MM+1)-1:0]      msg_len;
    logic                         frame_done;
    logic [1:0]                   state_o;

    scroll_msg_ctrl_if #(.CHAR_WIDTH(CW)) wr_if ();

    scroll_msg_ctrl #(
        .MSG_MAX      (MM),
        .CHAR_WIDTH   (CW),
        .NUM_DISPLAYS (ND),
        .HOLD_TICKS   (HT)
    ) dut (
        .clk_50mhz     (clk),
        .reset_n       (reset_n),
        .tick          (tick),
        .dir_switch    (dir_switch),
        .pause_switch  (pause_switch),
        .wr            (wr_if),
        .display_chars (display_chars),
        .msg_len       (msg_len),
        .frame_done    (frame_done),
        .state_o       (state_o)
    );

    logic [47:0] disp_flat;
    always_comb begin
        disp_flat = '0;
        for (int k = 0; k < ND; k++) begin
            disp_flat[k*CW +: CW] = display_chars[k];
        end
    end

    // ---------------- scoreboard ----------------
    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   fd_seen  = 0;

    function automatic logic [47:0] actual_of(input int kind);
        logic [47:0] v;
        v = '0;
        case (kind)
            K_STATE: v = 48'(state_o);
            K_LEN:   v = 48'(msg_len);
            K_DISP:  v = disp_flat;
            K_FD:    v = 48'(frame_done);
            default: v = 48'(wr_if.wr_ready);
        endcase
        return v;
    endfunction

    task automatic compare(input exp_t e);
        logic [47:0] act;
        act = actual_of(e.kind);
        checks++;
        if (act !== e.exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", e.name, cyc, act, e.exp);
        end
    endtask

    task automatic expect_at(input int dly, input int kind, input logic [47:0] v,
                             input string name);
        exp_t e;
        e.due  = cyc + dly;
        e.kind = kind;
        e.exp  = v;
        e.name = name;
        exp_q.push_back(e);
    endtask

    // Monitor: compares every expectation that falls due on this cycle.
    always @(negedge clk) begin : monitor
        int i;
        if (frame_done === 1'b1) fd_seen++;
        i = 0;
        while (i < exp_q.size()) begin
            if (exp_q[i].due == cyc) begin
                compare(exp_q[i]);
                exp_q.delete(i);
            end else begin
                i++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) step();
    endtask

    task automatic send_beat(input logic [7:0] c, input logic last);
        wr_if.wr_valid = 1'b1;
        wr_if.wr_char  = c;
        wr_if.wr_last  = last;
        step();
        wr_if.wr_valid = 1'b0;
        wr_if.wr_last  = 1'b0;
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        reset_n        = 1'b0;
        tick           = 1'b0;
        dir_switch     = 1'b1;
        pause_switch   = 1'b0;
        wr_if.wr_valid = 1'b0;
        wr_if.wr_char  = '0;
        wr_if.wr_last  = 1'b0;

        // Reset values
        wait_cycles(2);
        expect_at(0, K_STATE, 48'd0, "rst_state");
        expect_at(0, K_LEN,   48'd0, "rst_len");
        expect_at(0, K_DISP,  SPACES, "rst_disp");
        expect_at(0, K_RDY,   48'd1, "rst_ready");
        expect_at(0, K_FD,    48'd0, "rst_fd");
        step();
        reset_n = 1'b1;
        step();

        // Load "HELLO"
        expect_at(1, K_STATE, 48'd1, "load_state");
        send_beat("H", 1'b0);
        expect_at(1, K_LEN,  48'd2, "load_len2");
        expect_at(2, K_DISP, SPACES, "load_disp");
        send_beat("E", 1'b0);
        expect_at(1, K_STATE, 48'd1, "load_tick_ignored");
        pulse_tick();
        send_beat("L", 1'b0);
        send_beat("L", 1'b0);
        expect_at(1, K_STATE, 48'd2, "hello_state");
        expect_at(1, K_LEN,   48'd5, "hello_len");
        expect_at(2, K_DISP,  W_HELLOH, "hello_win");
        send_beat("O", 1'b1);
        wait_cycles(2);

        // dir=0 from pos 0: wrap away to pos 4, no frame_done
        dir_switch = 1'b0;
        expect_at(1, K_FD,    48'd0, "dirl_no_fd");
        expect_at(1, K_STATE, 48'd2, "dirl_state");
        expect_at(2, K_DISP,  W_OHELLO, "dirl_win");
        pulse_tick();
        wait_cycles(2);

        // Direction change alone does not move pos
        dir_switch = 1'b1;
        expect_at(2, K_DISP, W_OHELLO, "dir_no_jump");
        wait_cycles(3);

        // dir=1 from pos 4: wrap into 0, frame_done and HOLD
        expect_at(1, K_FD,    48'd1, "wrap_fd");
        expect_at(2, K_FD,    48'd0, "wrap_fd_pulse");
        expect_at(1, K_STATE, 48'd3, "hold_enter");
        expect_at(2, K_DISP,  W_HELLOH, "hold_win");
        pulse_tick();
        wait_cycles(2);

        expect_at(1, K_STATE, 48'd3, "hold_t1");
        pulse_tick();
        wait_cycles(1);
        pause_switch = 1'b1;
        expect_at(1, K_STATE, 48'd3, "hold_paused");
        pulse_tick();
        pause_switch = 1'b0;
        wait_cycles(1);
        expect_at(1, K_STATE, 48'd3, "hold_t2");
        pulse_tick();
        wait_cycles(1);
        expect_at(1, K_STATE, 48'd2, "hold_exit");
        expect_at(2, K_DISP,  W_HELLOH, "hold_exit_win");
        pulse_tick();
        wait_cycles(2);
        expect_at(2, K_DISP, W_ELLOHE, "after_hold_win");
        pulse_tick();
        wait_cycles(2);

        // Paused tick in SCROLL changes nothing
        pause_switch = 1'b1;
        expect_at(2, K_DISP, W_ELLOHE, "pause_scroll");
        pulse_tick();
        pause_switch = 1'b0;
        wait_cycles(2);

        // Steps to pos 4, then the loop-completing wrap
        pulse_tick();
        wait_cycles(1);
        pulse_tick();
        wait_cycles(1);
        expect_at(2, K_DISP, W_OHELLO, "pos4_win");
        pulse_tick();
        wait_cycles(2);
        expect_at(1, K_FD,    48'd1, "loop_fd");
        expect_at(1, K_STATE, 48'd3, "loop_hold");
        pulse_tick();
        wait_cycles(2);

        // Overflow: 20 characters into a 16-deep buffer
        for (int i = 0; i < 20; i++) begin
            if (i == 0) expect_at(1, K_STATE, 48'd1, "ovf_restart");
            if (i == 17) expect_at(1, K_RDY, 48'd1, "ovf_ready");
            if (i == 19) begin
                expect_at(1, K_LEN,   48'd16, "ovf_len");
                expect_at(1, K_STATE, 48'd2, "ovf_state");
                expect_at(2, K_DISP,  48'h414243444546, "ovf_win");
            end
            send_beat(8'h41 + 8'(i), (i == 19));
        end
        wait_cycles(2);
        dir_switch = 1'b0;
        expect_at(1, K_FD,   48'd0, "ovf_step_no_fd");
        expect_at(2, K_DISP, 48'h504142434445, "ovf_wrap_win");
        pulse_tick();
        wait_cycles(2);

        // Beat coinciding with a tick that would wrap: the write wins
        dir_switch     = 1'b1;
        tick           = 1'b1;
        wr_if.wr_valid = 1'b1;
        wr_if.wr_char  = "A";
        wr_if.wr_last  = 1'b0;
        expect_at(1, K_STATE, 48'd1, "reload_state");
        expect_at(1, K_LEN,   48'd1, "reload_len");
        expect_at(1, K_FD,    48'd0, "reload_no_fd");
        expect_at(2, K_DISP,  SPACES, "reload_disp");
        step();
        tick           = 1'b0;
        wr_if.wr_valid = 1'b0;
        expect_at(1, K_STATE, 48'd2, "az_state");
        expect_at(1, K_LEN,   48'd2, "az_len");
        expect_at(2, K_DISP,  48'h415A415A415A, "az_win");
        send_beat("Z", 1'b1);
        wait_cycles(2);

        // Single-character message
        expect_at(1, K_LEN,  48'd1, "one_len");
        expect_at(2, K_DISP, 48'h414141414141, "one_win");
        send_beat("A", 1'b1);
        wait_cycles(2);
        expect_at(1, K_FD,    48'd1, "one_fd1");
        expect_at(1, K_STATE, 48'd3, "one_hold");
        expect_at(2, K_DISP,  48'h414141414141, "one_win_hold");
        pulse_tick();
        wait_cycles(1);
        for (int i = 0; i < HT; i++) begin
            pulse_tick();
        end
        expect_at(1, K_FD, 48'd1, "one_fd2");
        pulse_tick();
        wait_cycles(2);

        // Asynchronous reset in the middle of a load
        send_beat("Q", 1'b0);
        #5;
        reset_n = 1'b0;
        #1;
        expect_at(0, K_STATE, 48'd0, "mid_rst_state");
        expect_at(0, K_LEN,   48'd0, "mid_rst_len");
        expect_at(0, K_DISP,  SPACES, "mid_rst_disp");
        step();
        reset_n = 1'b1;
        step();
        expect_at(1, K_LEN,  48'd1, "post_rst_len");
        expect_at(2, K_DISP, 48'h424242424242, "post_rst_win");
        send_beat("B", 1'b1);
        wait_cycles(4);

        // Totals
        checks++;
        if (fd_seen != 4) begin
            failures++;
            $display("FAIL fd_count got=%0d expected=%0d", fd_seen, 4);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL pending_expectations got=%0d expected=%0d", exp_q.size(), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
